// File: rtl/branch_ctrl.sv
// branch_ctrl: branch resolution and redirect controller for the 5-stage pipe.
//   Resolves the EX branch/jump against the prediction made at fetch, drives
//   the PC-select mux, the redirect target and the IF/ID + ID/EX flushes, and
//   keeps saturating branch / mispredict counters.
//   Optional feature macro: BRANCH_PREDICT_EN. When defined, a 2-bit BHT
//   provides dynamic prediction. When undefined, prediction is static not-taken.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_in            EX frozen this cycle (nothing resolves)
//   if_*                IF instruction info for prediction lookup
//   ex_*                EX instruction outcome for resolution/update
//   pred_taken, pc_sel  fetch-side prediction / PC mux select (combinational)
//   redirect_pc, flush_* EX redirect target and pipeline squashes
//   branch_cnt, mispred_cnt  saturating performance counters
module branch_ctrl #(
  parameter int BHT_ENTRIES = 16,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            if_valid,
  input  logic            if_is_branch,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  output logic            pred_taken,
  output logic [1:0]      pc_sel,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [15:0]     branch_cnt,
  output logic [15:0]     mispred_cnt
);

  localparam int IDXW = $clog2(BHT_ENTRIES);

  logic        res, br_res, mispred, redir;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] mispred_cnt_q, mispred_cnt_d;

  // A branch in EX during reset is discarded: gate resolution with rst.
  assign res     = ex_valid & ~stall_in & ~rst;
  assign br_res  = res & ex_is_branch;
  assign mispred = br_res & (ex_taken != ex_pred_taken);
  assign redir   = res & (ex_is_jump | (ex_is_branch & (ex_taken != ex_pred_taken)));

  // Fall-through only when a predicted-taken branch turned out not taken.
  assign redirect_pc = (ex_is_jump | ex_taken) ? ex_target : ex_pc + XLEN'(4);

  assign flush_if_id = redir;
  assign flush_id_ex = redir;

  always_comb begin
    pc_sel = 2'b00;
    if (redir)                                   pc_sel = 2'b10;
    else if (if_valid & if_is_branch & pred_taken) pc_sel = 2'b01;
  end

`ifdef BRANCH_PREDICT_EN
  logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;
  logic [IDXW-1:0]             if_idx, ex_idx;

  assign if_idx = if_pc[IDXW+1:2];
  assign ex_idx = ex_pc[IDXW+1:2];

  // Reads bht_q directly, so a same-index write this cycle is not visible.
  assign pred_taken = ~rst & if_valid & if_is_branch & bht_q[if_idx][1];

  always_comb begin
    bht_d = bht_q;
    if (br_res) begin
      if (ex_taken && bht_q[ex_idx] != 2'b11)       bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      else if (!ex_taken && bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bht_q <= {BHT_ENTRIES{2'b01}};
    else     bht_q <= bht_d;
  end

  logic unused_ok;
  assign unused_ok = ^{if_target, if_pc};
`else
  assign pred_taken = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{if_target, if_pc};
`endif

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (br_res && branch_cnt_q != 16'hFFFF)   branch_cnt_d  = branch_cnt_q + 16'd1;
    if (mispred && mispred_cnt_q != 16'hFFFF) mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
  localparam int XLEN = 32;
`ifdef BRANCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, stall_in, if_valid, if_is_branch;
  logic [XLEN-1:0] if_pc, if_target;
  logic            ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [XLEN-1:0] ex_pc, ex_target;
  logic            pred_taken, flush_if_id, flush_id_ex;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] redirect_pc;
  logic [15:0]     branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_ctrl #(.BHT_ENTRIES(16), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .if_valid(if_valid), .if_is_branch(if_is_branch), .if_pc(if_pc), .if_target(if_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .pred_taken(pred_taken), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic drive_ex(input logic v, input logic br, input logic jp, input logic tk,
                          input logic pt, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tg);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jp; ex_taken = tk;
    ex_pred_taken = pt; ex_pc = pc; ex_target = tg;
  endtask

  task automatic drive_if(input logic v, input logic br, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] tg);
    if_valid = v; if_is_branch = br; if_pc = pc; if_target = tg;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; stall_in = 1'b0;
    drive_ex(1, 1, 0, 1, 0, 32'h100, 32'h140);
    drive_if(1, 1, 32'h100, 32'h140);
    #1;
    checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL rst_pc_sel got %0d want 0", pc_sel); end
    checks++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL rst_flush got %b%b want 00", flush_if_id, flush_id_ex); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred got %b want 0", pred_taken); end
    @(negedge clk);
    rst = 1'b0;
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (branch_cnt !== 16'd0) begin errors++; $display("FAIL rst_bcnt got %0d want 0", branch_cnt); end
    checks++; if (mispred_cnt !== 16'd0) begin errors++; $display("FAIL rst_mcnt got %0d want 0", mispred_cnt); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cold_pred got %b want 0", pred_taken); end
    checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL cold_pc_sel got %0d want 0", pc_sel); end
  endtask

  task automatic test_learn();
    @(negedge clk);
    drive_if(0, 0, 0, 0);
    drive_ex(1, 1, 0, 1, 0, 32'h100, 32'h140);
    #1;
    checks++; if (pc_sel !== 2'b10) begin errors++; $display("FAIL learn1_pc_sel got %0d want 2", pc_sel); end
    checks++; if (redirect_pc !== 32'h140) begin errors++; $display("FAIL learn1_target got %h want 140", redirect_pc); end
    checks++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL learn1_flush got %b%b want 11", flush_if_id, flush_id_ex); end
    @(negedge clk);
    // Entry is now 10: the carried prediction matches the BHT state.
    drive_ex(1, 1, 0, 1, PE, 32'h100, 32'h140);
    drive_if(1, 1, 32'h100, 32'h140);
    #1;
    checks++; if (pred_taken !== PE) begin errors++; $display("FAIL learn2_pred got %b want %b", pred_taken, PE); end
    checks++; if (pc_sel !== (PE ? 2'b01 : 2'b10)) begin errors++; $display("FAIL learn2_pc_sel got %0d want %0d", pc_sel, PE ? 1 : 2); end
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (pred_taken !== PE) begin errors++; $display("FAIL learn3_pred got %b want %b", pred_taken, PE); end
    checks++; if (pc_sel !== {1'b0, PE}) begin errors++; $display("FAIL learn3_pc_sel got %0d want %0d", pc_sel, PE); end
    checks++; if (branch_cnt !== 16'd2) begin errors++; $display("FAIL learn_bcnt got %0d want 2", branch_cnt); end
    checks++; if (mispred_cnt !== 16'(2 - PE)) begin errors++; $display("FAIL learn_mcnt got %0d want %0d", mispred_cnt, 2 - PE); end
  endtask

  task automatic test_mispred_nt();
    @(negedge clk);
    drive_if(0, 0, 0, 0);
    drive_ex(1, 1, 0, 0, 1, 32'h200, 32'h240);
    #1;
    checks++; if (pc_sel !== 2'b10) begin errors++; $display("FAIL nt_pc_sel got %0d want 2", pc_sel); end
    checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL nt_target got %h want 204", redirect_pc); end
    checks++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL nt_flush got %b%b want 11", flush_if_id, flush_id_ex); end
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL nt_flush_after got %b%b want 00", flush_if_id, flush_id_ex); end
    checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL nt_pc_sel_after got %0d want 0", pc_sel); end
    checks++; if (branch_cnt !== 16'd3) begin errors++; $display("FAIL nt_bcnt got %0d want 3", branch_cnt); end
    checks++; if (mispred_cnt !== 16'(3 - PE)) begin errors++; $display("FAIL nt_mcnt got %0d want %0d", mispred_cnt, 3 - PE); end
  endtask

  task automatic test_jump();
    @(negedge clk);
    drive_if(1, 1, 32'h100, 32'h140);
    // Jump with ex_taken low: target must still be ex_target, BHT untouched.
    drive_ex(1, 0, 1, 0, 0, 32'h100, 32'h300);
    #1;
    checks++; if (pc_sel !== 2'b10) begin errors++; $display("FAIL jmp_pc_sel got %0d want 2", pc_sel); end
    checks++; if (redirect_pc !== 32'h300) begin errors++; $display("FAIL jmp_target got %h want 300", redirect_pc); end
    checks++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL jmp_flush got %b%b want 11", flush_if_id, flush_id_ex); end
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (pred_taken !== PE) begin errors++; $display("FAIL jmp_bht got %b want %b", pred_taken, PE); end
    checks++; if (branch_cnt !== 16'd3) begin errors++; $display("FAIL jmp_bcnt got %0d want 3", branch_cnt); end
    checks++; if (mispred_cnt !== 16'(3 - PE)) begin errors++; $display("FAIL jmp_mcnt got %0d want %0d", mispred_cnt, 3 - PE); end
  endtask

  task automatic test_same_index();
    @(negedge clk);
    drive_if(1, 1, 32'h100, 32'h140);
    drive_ex(1, 1, 0, 0, 0, 32'h100, 32'h140);
    #1;
    checks++; if (pred_taken !== PE) begin errors++; $display("FAIL same_pre got %b want %b", pred_taken, PE); end
    checks++; if (pc_sel !== {1'b0, PE}) begin errors++; $display("FAIL same_pc_sel got %0d want %0d", pc_sel, PE); end
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_post got %b want 0", pred_taken); end
    checks++; if (branch_cnt !== 16'd4) begin errors++; $display("FAIL same_bcnt got %0d want 4", branch_cnt); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    drive_if(0, 0, 0, 0);
    drive_ex(1, 1, 0, 1, 0, 32'h308, 32'h380);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL stall_pc_sel[%0d] got %0d want 0", i, pc_sel); end
      checks++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL stall_flush[%0d] got %b%b want 00", i, flush_if_id, flush_id_ex); end
      checks++; if (branch_cnt !== 16'd4 || mispred_cnt !== 16'(3 - PE)) begin errors++; $display("FAIL stall_cnt[%0d] got %0d/%0d want 4/%0d", i, branch_cnt, mispred_cnt, 3 - PE); end
      @(negedge clk);
    end
    stall_in = 1'b0;
    #1;
    checks++; if (pc_sel !== 2'b10) begin errors++; $display("FAIL rel_pc_sel got %0d want 2", pc_sel); end
    checks++; if (redirect_pc !== 32'h380) begin errors++; $display("FAIL rel_target got %h want 380", redirect_pc); end
    checks++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL rel_flush got %b%b want 11", flush_if_id, flush_id_ex); end
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL rel_flush_after got %b want 0", flush_if_id); end
    checks++; if (branch_cnt !== 16'd5) begin errors++; $display("FAIL rel_bcnt got %0d want 5", branch_cnt); end
    checks++; if (mispred_cnt !== 16'(4 - PE)) begin errors++; $display("FAIL rel_mcnt got %0d want %0d", mispred_cnt, 4 - PE); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    drive_ex(1, 1, 0, 0, 0, 32'h404, 32'h440);
    repeat (65540) @(negedge clk);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (branch_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_bcnt got %h want ffff", branch_cnt); end
    checks++; if (mispred_cnt !== 16'(4 - PE)) begin errors++; $display("FAIL sat_mcnt got %0d want %0d", mispred_cnt, 4 - PE); end
    checks++; if (pc_sel !== 2'b00) begin errors++; $display("FAIL sat_pc_sel got %0d want 0", pc_sel); end
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0;
    drive_if(0, 0, 0, 0);
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_learn();
    test_mispred_nt();
    test_jump();
    test_same_index();
    test_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
